// File: rtl/bin_to_xs3_seq_if.sv
// Valid/ready handshake bundle for the binary-to-excess-3 encoder.
// The master drives the binary word and accepts the result; the slave is the encoder.
interface bin_to_xs3_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   xs3_out;
  logic                  overflow;
  logic                  busy;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, xs3_out, overflow, busy
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, xs3_out, overflow, busy
  );
endinterface

// File: rtl/bin_to_xs3_seq.sv
// Sequential binary-to-excess-3 encoder: double dabble one bit per clock,
// then +3 per digit, with a valid/ready handshake on both sides.
module bin_to_xs3_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic               clk,
  input  logic               rst,
  bin_to_xs3_seq_if.slave    bus
);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, CONV, DONE} state_t;

  state_t             state;
  logic [BCD_W-1:0]   bcd;
  logic [BIN_W-1:0]   shreg;
  logic [CNT_W-1:0]   count;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   xs3_next;

  // Digits are adjusted independently; no carry crosses a digit boundary.
  always_comb begin
    bcd_adj  = bcd;
    xs3_next = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      xs3_next[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bcd           <= '0;
      shreg         <= '0;
      count         <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.xs3_out   <= '0;
      bus.overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            shreg        <= bus.bin_in;
            bcd          <= '0;
            count        <= '0;
            bus.overflow <= 1'b0;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          // A bit falling off the top digit means the value needs more digits.
          bcd   <= {bcd_adj[BCD_W-2:0], shreg[BIN_W-1]};
          shreg <= shreg << 1;
          if (bcd_adj[BCD_W-1]) begin
            bus.overflow <= 1'b1;
          end
          count <= count + 1'b1;
          if (count == CNT_W'(BIN_W - 1)) begin
            state <= CONV;
          end
        end
        CONV: begin
          bus.xs3_out   <= xs3_next;
          bus.busy      <= 1'b0;
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule
